// File: rtl/bcd_time_counter.sv
// bcd_time_counter: BCD MM:SS up/down counter stepped by the rising edge of a
// divided-clock level (tick_in) sampled in the clk domain.
//
// Parameters:
//   MAX_MIN  highest minute value (1..99); count range 00:00..MAX_MIN:59
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   tick_in                  divided-clock level; a rising edge requests one step
//   start, stop              pulses; enter RUNNING / STOPPED (stop wins)
//   up_dn                    1 = count up, 0 = count down (sampled on step cycle)
//   load, load_mt/mo/st/so   pulse plus BCD time to load
//   min_t, min_o, sec_t, sec_o  digit registers
//   running                  1 while in RUNNING
//   zero                     time == 00:00
//   wrap                     one-cycle pulse on rollover
//   load_err                 one-cycle pulse on a rejected load
//
// Optional feature (macro SEG7_EN): seg_mt, seg_mo, seg_st, seg_so, active-low
// 7-segment decodes (bit order gfedcba) of the digit registers.
module bcd_time_counter #(
  parameter int unsigned MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       start,
  input  logic       stop,
  input  logic       up_dn,
  input  logic       load,
  input  logic [3:0] load_mt,
  input  logic [3:0] load_mo,
  input  logic [2:0] load_st,
  input  logic [3:0] load_so,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [2:0] sec_t,
  output logic [3:0] sec_o,
  output logic       running,
  output logic       zero,
  output logic       wrap,
`ifdef SEG7_EN
  output logic [6:0] seg_mt,
  output logic [6:0] seg_mo,
  output logic [6:0] seg_st,
  output logic [6:0] seg_so,
`endif
  output logic       load_err
);

  localparam logic [3:0] MaxMt     = 4'(MAX_MIN / 10);
  localparam logic [3:0] MaxMo     = 4'(MAX_MIN % 10);
  localparam logic [7:0] MaxMinVal = 8'(MAX_MIN);

  typedef enum logic [0:0] {StStopped, StRunning} state_e;

  state_e     state_q, state_d;
  logic       tick_q;
  logic [3:0] mt_q, mt_d;
  logic [3:0] mo_q, mo_d;
  logic [2:0] st_q, st_d;
  logic [3:0] so_q, so_d;
  logic       wrap_q, wrap_d;
  logic       load_err_q, load_err_d;

  logic       step;
  logic       load_ok;
  logic [7:0] load_min_val;

  // Edge detect gated by the current (registered) state, so a step in the
  // same cycle as start is not taken.
  assign step = tick_in & ~tick_q & (state_q == StRunning);

  assign load_min_val = ({4'd0, load_mt} * 8'd10) + {4'd0, load_mo};
  assign load_ok = (load_mo <= 4'd9) && (load_st <= 3'd5) && (load_so <= 4'd9) &&
                   (load_min_val <= MaxMinVal);

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = StStopped;
    end else if (start) begin
      state_d = StRunning;
    end
  end

  always_comb begin
    mt_d       = mt_q;
    mo_d       = mo_q;
    st_d       = st_q;
    so_d       = so_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      // A load always wins; a coincident step is dropped.
      if (load_ok) begin
        mt_d = load_mt;
        mo_d = load_mo;
        st_d = load_st;
        so_d = load_so;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (step) begin
      if (up_dn) begin
        if (so_q != 4'd9) begin
          so_d = so_q + 4'd1;
        end else begin
          so_d = 4'd0;
          if (st_q != 3'd5) begin
            st_d = st_q + 3'd1;
          end else begin
            st_d = 3'd0;
            if (mt_q == MaxMt && mo_q == MaxMo) begin
              mt_d   = 4'd0;
              mo_d   = 4'd0;
              wrap_d = 1'b1;
            end else if (mo_q == 4'd9) begin
              mo_d = 4'd0;
              mt_d = mt_q + 4'd1;
            end else begin
              mo_d = mo_q + 4'd1;
            end
          end
        end
      end else begin
        if (so_q != 4'd0) begin
          so_d = so_q - 4'd1;
        end else begin
          so_d = 4'd9;
          if (st_q != 3'd0) begin
            st_d = st_q - 3'd1;
          end else begin
            st_d = 3'd5;
            if (mt_q == 4'd0 && mo_q == 4'd0) begin
              mt_d   = MaxMt;
              mo_d   = MaxMo;
              wrap_d = 1'b1;
            end else if (mo_q == 4'd0) begin
              mo_d = 4'd9;
              mt_d = mt_q - 4'd1;
            end else begin
              mo_d = mo_q - 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StStopped;
      tick_q     <= 1'b0;
      mt_q       <= 4'd0;
      mo_q       <= 4'd0;
      st_q       <= 3'd0;
      so_q       <= 4'd0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_in;
      mt_q       <= mt_d;
      mo_q       <= mo_d;
      st_q       <= st_d;
      so_q       <= so_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign min_t    = mt_q;
  assign min_o    = mo_q;
  assign sec_t    = st_q;
  assign sec_o    = so_q;
  assign running  = (state_q == StRunning);
  assign zero     = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 3'd0) && (so_q == 4'd0);
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

`ifdef SEG7_EN
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign seg_mt = seg_decode(mt_q);
  assign seg_mo = seg_decode(mo_q);
  assign seg_st = seg_decode({1'b0, st_q});
  assign seg_so = seg_decode(so_q);
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
module tb_bcd_time_counter;

  logic       clk = 1'b0;
  logic       rst, tick_in, start, stop, up_dn, load;
  logic [3:0] load_mt, load_mo, load_so;
  logic [2:0] load_st;
  logic [3:0] min_t, min_o, sec_o;
  logic [2:0] sec_t;
  logic       running, zero, wrap, load_err;
`ifdef SEG7_EN
  logic [6:0] seg_mt, seg_mo, seg_st, seg_so;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd_time_counter #(.MAX_MIN(59)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick_in  (tick_in),
    .start    (start),
    .stop     (stop),
    .up_dn    (up_dn),
    .load     (load),
    .load_mt  (load_mt),
    .load_mo  (load_mo),
    .load_st  (load_st),
    .load_so  (load_so),
    .min_t    (min_t),
    .min_o    (min_o),
    .sec_t    (sec_t),
    .sec_o    (sec_o),
    .running  (running),
    .zero     (zero),
    .wrap     (wrap),
`ifdef SEG7_EN
    .seg_mt   (seg_mt),
    .seg_mo   (seg_mo),
    .seg_st   (seg_st),
    .seg_so   (seg_so),
`endif
    .load_err (load_err)
  );

  wire [14:0] tm = {min_t, min_o, sec_t, sec_o};

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] mt, input logic [3:0] mo, input logic [2:0] st,
                         input logic [3:0] so);
    load_mt = mt; load_mo = mo; load_st = st; load_so = so; load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick_in = 1'b1; start = 0; stop = 0; up_dn = 1; load = 0;
    load_mt = 0; load_mo = 0; load_st = 0; load_so = 0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    n_cmp++; if (tm !== 15'h0000) begin
      $display("FAIL reset_digits got %h want %h", tm, 15'h0000); n_bad++; end
    n_cmp++; if ({running, wrap, load_err, zero} !== 4'b0001) begin
      $display("FAIL reset_flags got %b want %b", {running, wrap, load_err, zero}, 4'b0001);
      n_bad++; end
    start = 1'b1; cyc(); start = 1'b0;
    n_cmp++; if (running !== 1'b1) begin
      $display("FAIL start_running got %b want 1", running); n_bad++; end
    cyc(); cyc();
    n_cmp++; if (tm !== 15'h0000) begin
      $display("FAIL held_tick_no_step got %h want %h", tm, 15'h0000); n_bad++; end
    tick_in = 1'b0; cyc();
    tick_in = 1'b1;
    #1;
    n_cmp++; if (tm !== 15'h0000) begin
      $display("FAIL edge_cycle_n got %h want %h", tm, 15'h0000); n_bad++; end
    cyc();
    n_cmp++; if (tm !== {4'd0, 4'd0, 3'd0, 4'd1}) begin
      $display("FAIL first_edge got %h want %h", tm, {4'd0, 4'd0, 3'd0, 4'd1}); n_bad++; end
    tick_in = 1'b0; cyc();
  endtask

  task automatic test_count_up();
    up_dn = 1'b1;
    do_load(4'd0, 4'd3, 3'd5, 4'd8);
    n_cmp++; if (tm !== {4'd0, 4'd3, 3'd5, 4'd8}) begin
      $display("FAIL load_0358 got %h want %h", tm, {4'd0, 4'd3, 3'd5, 4'd8}); n_bad++; end
    tick_in = 1; cyc(); tick_in = 0; cyc();
    n_cmp++; if (tm !== {4'd0, 4'd3, 3'd5, 4'd9}) begin
      $display("FAIL up_0359 got %h want %h", tm, {4'd0, 4'd3, 3'd5, 4'd9}); n_bad++; end
    tick_in = 1; cyc(); tick_in = 0;
    n_cmp++; if (tm !== {4'd0, 4'd4, 3'd0, 4'd0}) begin
      $display("FAIL up_0400 got %h want %h", tm, {4'd0, 4'd4, 3'd0, 4'd0}); n_bad++; end
    cyc();
    do_load(4'd0, 4'd9, 3'd5, 4'd9);
    tick_in = 1; cyc(); tick_in = 0; cyc();
    n_cmp++; if (tm !== {4'd1, 4'd0, 3'd0, 4'd0}) begin
      $display("FAIL up_1000 got %h want %h", tm, {4'd1, 4'd0, 3'd0, 4'd0}); n_bad++; end
  endtask

  task automatic test_wrap_up();
    up_dn = 1'b1;
    do_load(4'd5, 4'd9, 3'd5, 4'd9);
    tick_in = 1; cyc(); tick_in = 0;
    n_cmp++; if ({tm, wrap, zero} !== {15'h0000, 2'b11}) begin
      $display("FAIL wrap_up got %h w%b z%b want 0000 w1 z1", tm, wrap, zero); n_bad++; end
    cyc();
    n_cmp++; if (wrap !== 1'b0) begin
      $display("FAIL wrap_up_one_cycle got %b want 0", wrap); n_bad++; end
  endtask

  task automatic test_count_down();
    up_dn = 1'b0;
    tick_in = 1; cyc(); tick_in = 0;
    n_cmp++; if ({tm, wrap} !== {4'd5, 4'd9, 3'd5, 4'd9, 1'b1}) begin
      $display("FAIL wrap_dn got %h w%b want 5959 w1", tm, wrap); n_bad++; end
    cyc();
    n_cmp++; if (wrap !== 1'b0) begin
      $display("FAIL wrap_dn_one_cycle got %b want 0", wrap); n_bad++; end
    tick_in = 1; up_dn = 1'b0; cyc(); tick_in = 0; up_dn = 1'b1; cyc();
    n_cmp++; if (tm !== {4'd5, 4'd9, 3'd5, 4'd8}) begin
      $display("FAIL dn_5958 got %h want %h", tm, {4'd5, 4'd9, 3'd5, 4'd8}); n_bad++; end
    up_dn = 1'b0;
    do_load(4'd1, 4'd0, 3'd0, 4'd0);
    tick_in = 1; cyc(); tick_in = 0; cyc();
    n_cmp++; if (tm !== {4'd0, 4'd9, 3'd5, 4'd9}) begin
      $display("FAIL dn_0959 got %h want %h", tm, {4'd0, 4'd9, 3'd5, 4'd9}); n_bad++; end
  endtask

  task automatic test_load_err();
    do_load(4'd6, 4'd0, 3'd0, 4'd0);
    n_cmp++; if ({tm, load_err} !== {4'd0, 4'd9, 3'd5, 4'd9, 1'b1}) begin
      $display("FAIL load_6000_rej got %h e%b want 0959 e1", tm, load_err); n_bad++; end
    cyc();
    n_cmp++; if (load_err !== 1'b0) begin
      $display("FAIL load_err_one_cycle got %b want 0", load_err); n_bad++; end
    do_load(4'd0, 4'd0, 3'd6, 4'd1);
    n_cmp++; if ({tm, load_err} !== {4'd0, 4'd9, 3'd5, 4'd9, 1'b1}) begin
      $display("FAIL load_st6_rej got %h e%b want 0959 e1", tm, load_err); n_bad++; end
    do_load(4'd0, 4'd10, 3'd0, 4'd0);
    n_cmp++; if ({tm, load_err} !== {4'd0, 4'd9, 3'd5, 4'd9, 1'b1}) begin
      $display("FAIL load_mo10_rej got %h e%b want 0959 e1", tm, load_err); n_bad++; end
  endtask

  task automatic test_load_step_start_stop();
    up_dn = 1'b1;
    tick_in = 1; load_mt = 1; load_mo = 2; load_st = 3; load_so = 4; load = 1;
    cyc(); load = 0; tick_in = 0;
    n_cmp++; if ({tm, load_err, wrap} !== {4'd1, 4'd2, 3'd3, 4'd4, 2'b00}) begin
      $display("FAIL load_over_step got %h e%b w%b want 1234 e0 w0", tm, load_err, wrap);
      n_bad++; end
    start = 1; stop = 1; cyc(); start = 0; stop = 0;
    n_cmp++; if (running !== 1'b0) begin
      $display("FAIL start_stop_together got %b want 0", running); n_bad++; end
    tick_in = 1; cyc(); tick_in = 0; cyc(); tick_in = 1; cyc(); tick_in = 0; cyc();
    n_cmp++; if (tm !== {4'd1, 4'd2, 3'd3, 4'd4}) begin
      $display("FAIL stopped_frozen got %h want %h", tm, {4'd1, 4'd2, 3'd3, 4'd4}); n_bad++; end
    start = 1; tick_in = 1; cyc(); start = 0;
    n_cmp++; if ({tm, running} !== {4'd1, 4'd2, 3'd3, 4'd4, 1'b1}) begin
      $display("FAIL step_with_start got %h r%b want 1234 r1", tm, running); n_bad++; end
    tick_in = 0; cyc(); tick_in = 1; cyc(); tick_in = 0; cyc();
    n_cmp++; if (tm !== {4'd1, 4'd2, 3'd3, 4'd5}) begin
      $display("FAIL run_after_start got %h want %h", tm, {4'd1, 4'd2, 3'd3, 4'd5}); n_bad++; end
  endtask

`ifdef SEG7_EN
  task automatic test_seg7();
    do_load(4'd1, 4'd8, 3'd0, 4'd0);
    n_cmp++; if ({seg_mt, seg_mo, seg_st} !== {7'h79, 7'h00, 7'h40}) begin
      $display("FAIL seg_glyphs got %h %h %h want 79 00 40", seg_mt, seg_mo, seg_st); n_bad++; end
    force dut.mo_q = 4'hA;
    #1;
    n_cmp++; if (seg_mo !== 7'h7F) begin
      $display("FAIL seg_illegal got %h want 7f", seg_mo); n_bad++; end
    release dut.mo_q;
  endtask
`endif

  initial begin
    test_reset();
    test_count_up();
    test_wrap_up();
    test_count_down();
    test_load_err();
    test_load_step_start_stop();
`ifdef SEG7_EN
    test_seg7();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
